// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: state encodings, bus widths and the NOP word.
package instruction_fetch_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_WIDTH  = 32;

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's external signals: the instruction memory port, the
// redirect request from execute and the IR handshake towards decode.
// master = fetch stage, slave = its environment (memory, execute, decode).
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic [ADDR_WIDTH-1:0]  imem_address;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_target;
  logic [INSTR_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0]  ir_pc;
  logic                   ir_valid;
  logic                   ir_ready;
  logic                   misalign_fault;

  modport master (
    output imem_address,
    input  imem_data,
    input  redirect,
    input  redirect_target,
    output ir,
    output ir_pc,
    output ir_valid,
    input  ir_ready,
    output misalign_fault
  );

  modport slave (
    input  imem_address,
    output imem_data,
    output redirect,
    output redirect_target,
    input  ir,
    input  ir_pc,
    input  ir_valid,
    output ir_ready,
    input  misalign_fault
  );

endinterface

// File: rtl/InstructionMemory.sv
// Simple word-indexed instruction memory: combinational read, synchronous write
// port used to preload the program. Instantiated next to the fetch stage, not in it.
module InstructionMemory #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  // Program load port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_pc_register.sv
// Program counter for the fetch stage: reset vector, sequential increment and
// redirect mux. A redirect always wins over a sequential advance.
module pc_register
  import instruction_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned           PC_STEP      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  advance,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

  // PC update: redirect target first, else modulo-2^32 increment when a word is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_VECTOR;
    end else if (redirect) begin
      pc <= target;
    end else if (advance) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: presents the PC to instruction memory, captures the returned word
// into the IR and hands it to decode over ir_valid/ir_ready. Execute can redirect
// the PC; a redirect flushes the IR. One idle BOOT cycle follows reset.
// Optional build macro FETCH_ALIGN_CHECK_EN: a redirect to a non word-aligned
// target is refused, raises a sticky misalign_fault and stops all further fetching.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned           PC_STEP      = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  instruction_fetch_if.master bus
);

  fetch_state_t           state;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [INSTR_WIDTH-1:0] ir_q;
  logic [ADDR_WIDTH-1:0]  ir_pc_q;
  logic                   ir_valid_q;
  logic                   fault_q;
  logic                   redirect_bad;
  logic                   redirect_accept;
  logic                   load;
  logic                   pc_redirect;
  logic                   pc_advance;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_bad = (bus.redirect_target[1:0] != 2'b00);

  // Sticky fault: set by the first refused misaligned redirect, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else if (redirect_accept && redirect_bad) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign redirect_bad = 1'b0;
  assign fault_q      = 1'b0;
`endif

  // Redirects are ignored during BOOT and once the stage has faulted.
  assign redirect_accept = (state != FETCH_BOOT) && bus.redirect && !fault_q;
  assign load            = (state != FETCH_BOOT) && (!ir_valid_q || bus.ir_ready) && !fault_q;
  assign pc_redirect     = redirect_accept && !redirect_bad;
  assign pc_advance      = load && !redirect_accept;

  pc_register #(
    .RESET_VECTOR (RESET_VECTOR),
    .PC_STEP      (PC_STEP)
  ) u_pc_register (
    .clk      (clk),
    .reset_n  (reset_n),
    .advance  (pc_advance),
    .redirect (pc_redirect),
    .target   (bus.redirect_target),
    .pc       (pc)
  );

  // Fetch FSM plus IR register: a redirect flushes, otherwise a load captures the memory word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH_BOOT;
      ir_q       <= NOP_WORD;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      case (state)
        FETCH_BOOT: begin
          state <= FETCH_RUN;
        end
        default: begin
          if (fault_q) begin
            state <= FETCH_HOLD;
          end else if (redirect_accept) begin
            ir_valid_q <= 1'b0;
            state      <= redirect_bad ? FETCH_HOLD : FETCH_RUN;
          end else begin
            if (load) begin
              ir_q       <= bus.imem_data;
              ir_pc_q    <= pc;
              ir_valid_q <= 1'b1;
            end
            state <= (ir_valid_q && !bus.ir_ready) ? FETCH_HOLD : FETCH_RUN;
          end
        end
      endcase
    end
  end

  assign bus.imem_address   = pc;
  assign bus.ir             = ir_q;
  assign bus.ir_pc          = ir_pc_q;
  assign bus.ir_valid       = ir_valid_q;
  assign bus.misalign_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with an InstructionMemory beside it: a directed
// vector table for the basic fetch/stall/redirect/wrap sequence, hand-written
// reset and misalignment sequences, and a randomized run against a reference model.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic memWe = 1'b0;
  logic [5:0] memWaddr = '0;
  logic [31:0] memWdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] memModel [64];

  logic [31:0] mPc;
  logic [31:0] mIr;
  logic [31:0] mIrPc;
  logic mValid;
  logic mBoot;
  logic mFault;

  typedef struct {
    logic        redirect;
    logic [31:0] target;
    logic        ready;
    logic [31:0] expAddr;
    logic [31:0] expIrPc;
    logic        expValid;
  } vec_t;

  vec_t vecs [23];

  always #5 clk = ~clk;

  instruction_fetch_if fif ();

  instruction_fetch #(
    .RESET_VECTOR (32'h0000_0000),
    .PC_STEP      (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (fif)
  );

  InstructionMemory #(
    .DEPTH_LOG2 (6)
  ) imem (
    .clk   (clk),
    .we    (memWe),
    .waddr (memWaddr),
    .wdata (memWdata),
    .raddr (fif.imem_address[7:2]),
    .rdata (fif.imem_data)
  );

  task automatic applyStimulus(input logic redirect, input logic [31:0] target, input logic ready);
    fif.redirect        = redirect;
    fif.redirect_target = target;
    fif.ir_ready        = ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    mPc    = 32'h0;
    mIr    = 32'h0;
    mIrPc  = 32'h0;
    mValid = 1'b0;
    mBoot  = 1'b1;
    mFault = 1'b0;
  endtask

  // One clock of the fetch rules, using the inputs currently driven.
  task automatic stepModel();
    logic [31:0] idx;
    if (mBoot) begin
      mBoot = 1'b0;
    end else if (mFault) begin
      mFault = 1'b1;
    end else if (fif.redirect) begin
      mValid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (fif.redirect_target % 4 != 0) mFault = 1'b1;
      else mPc = fif.redirect_target;
`else
      mPc = fif.redirect_target;
`endif
    end else if (!mValid || fif.ir_ready) begin
      idx    = (mPc / 4) % 64;
      mIr    = memModel[idx];
      mIrPc  = mPc;
      mValid = 1'b1;
      mPc    = mPc + 32'd4;
    end
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, " imem_address"}, fif.imem_address, mPc);
    checkOutput({tag, " ir_valid"}, {31'b0, fif.ir_valid}, {31'b0, mValid});
    checkOutput({tag, " ir_pc"}, fif.ir_pc, mIrPc);
    checkOutput({tag, " ir"}, fif.ir, mIr);
    checkOutput({tag, " misalign_fault"}, {31'b0, fif.misalign_fault}, {31'b0, mFault});
  endtask

  task automatic runCycle(input string tag, input logic redirect, input logic [31:0] target, input logic ready);
    applyStimulus(redirect, target, ready);
    stepModel();
    tick();
    compareModel(tag);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    tick();
    reset_n = 1'b1;
    resetModel();
  endtask

  initial begin
    logic [31:0] expIr;
    logic [31:0] holdAddr;
    logic [31:0] tgt;

    vecs[0]  = '{1'b1, 32'h0000_0080, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0004, 32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0008, 32'h0000_0004, 1'b1};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 32'h0000_000C, 32'h0000_0008, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0010, 32'h0000_000C, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0014, 32'h0000_0010, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0014, 32'h0000_0010, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0014, 32'h0000_0010, 1'b1};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 32'h0000_0014, 32'h0000_0010, 1'b1};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0018, 32'h0000_0014, 1'b1};
    vecs[10] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0000_0040, 32'h0000_0014, 1'b0};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 32'h0000_0044, 32'h0000_0040, 1'b1};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 32'h0000_0044, 32'h0000_0040, 1'b1};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 32'h0000_0044, 32'h0000_0040, 1'b1};
    vecs[14] = '{1'b1, 32'h0000_0080, 1'b0, 32'h0000_0080, 32'h0000_0040, 1'b0};
    vecs[15] = '{1'b0, 32'h0,         1'b0, 32'h0000_0084, 32'h0000_0080, 1'b1};
    vecs[16] = '{1'b0, 32'h0,         1'b1, 32'h0000_0088, 32'h0000_0084, 1'b1};
    vecs[17] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h0000_0084, 1'b0};
    vecs[18] = '{1'b0, 32'h0,         1'b1, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1};
    vecs[19] = '{1'b0, 32'h0,         1'b1, 32'h0000_0004, 32'h0000_0000, 1'b1};
    vecs[20] = '{1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 32'h0000_0000, 1'b0};
    vecs[21] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'h0000_0000, 1'b0};
    vecs[22] = '{1'b0, 32'h0,         1'b1, 32'h0000_0204, 32'h0000_0200, 1'b1};

    applyStimulus(1'b0, 32'h0, 1'b1);

    // Preload the program while reset is held.
    for (int i = 0; i < 64; i++) begin
      memWe       = 1'b1;
      memWaddr    = 6'(i);
      memWdata    = $urandom;
      memModel[i] = memWdata;
      tick();
    end
    memWe = 1'b0;

    checkOutput("reset imem_address", fif.imem_address, 32'h0);
    checkOutput("reset ir", fif.ir, 32'h0);
    checkOutput("reset ir_pc", fif.ir_pc, 32'h0);
    checkOutput("reset ir_valid", {31'b0, fif.ir_valid}, 32'h0);
    checkOutput("reset misalign_fault", {31'b0, fif.misalign_fault}, 32'h0);

    reset_n = 1'b1;

    // Directed table: boot, streaming, stall, redirects, wrap, back-to-back redirects.
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].redirect, vecs[i].target, vecs[i].ready);
      tick();
      checkOutput($sformatf("vec%0d imem_address", i), fif.imem_address, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d ir_pc", i), fif.ir_pc, vecs[i].expIrPc);
      checkOutput($sformatf("vec%0d ir_valid", i), {31'b0, fif.ir_valid}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d misalign_fault", i), {31'b0, fif.misalign_fault}, 32'h0);
      if (vecs[i].expValid) begin
        expIr = memModel[(vecs[i].expIrPc / 4) % 64];
        checkOutput($sformatf("vec%0d ir", i), fif.ir, expIr);
      end
    end

    // Reset in the middle of a stream takes effect before the next edge.
    applyStimulus(1'b0, 32'h0, 1'b1);
    reset_n = 1'b0;
    #2;
    checkOutput("midreset imem_address", fif.imem_address, 32'h0);
    checkOutput("midreset ir", fif.ir, 32'h0);
    checkOutput("midreset ir_pc", fif.ir_pc, 32'h0);
    checkOutput("midreset ir_valid", {31'b0, fif.ir_valid}, 32'h0);
    tick();
    reset_n = 1'b1;
    resetModel();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF8 | (tgt & 32'h4);
      runCycle("rand", ($urandom_range(7) == 0), tgt, ($urandom_range(3) != 0));
    end

    // Misaligned redirect target.
    doReset();
    runCycle("mis boot", 1'b0, 32'h0, 1'b1);
    runCycle("mis load", 1'b0, 32'h0, 1'b1);
    holdAddr = fif.imem_address;
    runCycle("mis redirect", 1'b1, 32'h0000_0042, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("mis pc kept", fif.imem_address, holdAddr);
    checkOutput("mis fault set", {31'b0, fif.misalign_fault}, 32'h1);
`else
    checkOutput("mis target used", fif.imem_address, 32'h0000_0042);
    checkOutput("mis no fault", {31'b0, fif.misalign_fault}, 32'h0);
`endif
    runCycle("mis after1", 1'b0, 32'h0, 1'b1);
    runCycle("mis after2", 1'b1, 32'h0000_0080, 1'b1);
    runCycle("mis after3", 1'b0, 32'h0, 1'b1);
    runCycle("mis after4", 1'b0, 32'h0, 1'b0);
    reset_n = 1'b0;
    #2;
    checkOutput("mis reset fault", {31'b0, fif.misalign_fault}, 32'h0);
    checkOutput("mis reset ir_valid", {31'b0, fif.ir_valid}, 32'h0);
    tick();
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
